// File: rtl/sig_delay_pkg.sv
// sig_delay_pkg: shared constants and helpers for the variable delay line.
// Holds the default geometry, a clog2 helper and the delay clamp function.
package sig_delay_pkg;

    localparam int BUS_BITS_DEF  = 2;
    localparam int MAX_DELAY_DEF = 16;

    typedef struct packed {
        logic [31:0] d_eff;
        logic        clamped;
    } clamp_t;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Zero maps to one, anything past max_d saturates; both flag clamped.
    function automatic clamp_t clamp(input int req, input int max_d);
        clamp_t c;
        c.d_eff   = req;
        c.clamped = 1'b0;
        if (req == 0) begin
            c.d_eff   = 1;
            c.clamped = 1'b1;
        end else if (req > max_d) begin
            c.d_eff   = max_d;
            c.clamped = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sig_delay_var_ram.sv
// sdp_ram: one write port, one registered read port.
// A read of the address being written returns the new data.
module sdp_ram #(
    parameter int W     = 2,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [DEPTH];

    // Storage write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; forwarding makes a one-deep delay a plain flop.
    always_ff @(posedge clk) begin
        if (re) q <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/sig_delay_var.sv
// sig_delay_var: run-time programmable delay line on a circular RAM.
// Macro SIG_DELAY_VAR_ZERO_EN turns i_delay=0 into a combinational bypass.
module sig_delay_var
    import sig_delay_pkg::*;
#(
    parameter int BUS_BITS  = BUS_BITS_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = clog2(MAX_DELAY + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ce,
    input  logic [DELAY_W-1:0]  i_delay,
    input  logic [BUS_BITS-1:0] i_bus,
    output logic [BUS_BITS-1:0] o_bus,
    output logic                o_valid,
    output logic                o_clamped
);

    localparam int AW = clog2(MAX_DELAY);
    localparam int SW = clog2(2 * MAX_DELAY + 1);

    localparam logic [AW-1:0]      WP_LAST = AW'(MAX_DELAY - 1);
    localparam logic [DELAY_W-1:0] WC_MAX  = DELAY_W'(MAX_DELAY);
    localparam logic [SW-1:0]      RD_OFS  = SW'(MAX_DELAY + 1);
    localparam logic [SW-1:0]      DEPTH   = SW'(MAX_DELAY);

    int                 req;
    clamp_t             cl;
    logic [DELAY_W-1:0] d_eff;
    logic               clamped_eff;
    logic               bypass;
    logic               unused_bits;

    logic [AW-1:0]       wp;
    logic [DELAY_W-1:0]  wc;
    logic [DELAY_W-1:0]  wc_next;
    logic [SW-1:0]       rd_sum;
    logic [AW-1:0]       raddr;
    logic                en;
    logic                valid_q;
    logic                clamped_q;
    logic [BUS_BITS-1:0] ram_q;

    assign req         = 32'(i_delay);
    assign cl          = clamp(req, MAX_DELAY);
    assign d_eff       = cl.d_eff[DELAY_W-1:0];
    assign unused_bits = ^cl.d_eff[31:DELAY_W];

`ifdef SIG_DELAY_VAR_ZERO_EN
    assign bypass      = (i_delay == '0);
    assign clamped_eff = cl.clamped & ~bypass;
`else
    assign bypass      = 1'b0;
    assign clamped_eff = cl.clamped;
`endif

    assign en      = i_ce & ~rst;
    assign wc_next = (wc == WC_MAX) ? wc : wc + 1'b1;

    // wp + MAX + 1 - D stays non-negative for D in 1..MAX.
    assign rd_sum = SW'(wp) + RD_OFS - SW'(d_eff);
    assign raddr  = (rd_sum >= DEPTH) ? AW'(rd_sum - DEPTH)
                                      : AW'(rd_sum);

    // Pointer, fill count and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp        <= '0;
            wc        <= '0;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else if (i_ce) begin
            wp        <= (wp == WP_LAST) ? '0 : wp + 1'b1;
            wc        <= wc_next;
            valid_q   <= (wc_next >= d_eff);
            clamped_q <= clamped_eff;
        end
    end

    sdp_ram #(
        .W     (BUS_BITS),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (en),
        .waddr (wp),
        .wdata (i_bus),
        .re    (en),
        .raddr (raddr),
        .q     (ram_q)
    );

    assign o_bus     = bypass ? i_bus
                     : (valid_q ? ram_q : '0);
    assign o_valid   = bypass ? ~rst : valid_q;
    assign o_clamped = bypass ? 1'b0 : clamped_q;

endmodule
